// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and constants for the boot loader.
//   state_t      loader FSM states
//   FIELD_BYTES  bytes per stream field (address, count, data, checksum)
//   WORD_BYTES   bytes per memory word (address stride)
//   LANE_LAST    byte-lane index that completes a field
package boot_loader_pkg;

  localparam int unsigned FIELD_BYTES = 4;
  localparam int unsigned WORD_BYTES  = 4;

  localparam logic [1:0] LANE_LAST = 2'(FIELD_BYTES - 1);

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit fields from a byte stream.
//   CLK, RESET       clock, async active-low reset
//   byte_valid_i     a byte is transferred this cycle
//   byte_i           the transferred byte
//   word_done_o      pulse: this transfer completes a field
//   word_o           assembled field, valid while word_done_o is high
// The fourth byte is not stored: it is merged combinationally so the
// completed field is usable in the same cycle as its last byte.
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q;
  logic [23:0] asm_q;

  assign word_done_o = byte_valid_i && (lane_q == LANE_LAST);
  assign word_o      = {byte_i, asm_q};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lane_q <= 2'd0;
      asm_q  <= 24'd0;
    end else if (byte_valid_i) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0:    asm_q[7:0]   <= byte_i;
        2'd1:    asm_q[15:8]  <= byte_i;
        2'd2:    asm_q[23:16] <= byte_i;
        default: asm_q        <= asm_q;
      endcase
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a program image from a byte stream into memory and
// releases the processor core once the image is complete.
//   CLK, RESET            clock, async active-low reset
//   in_valid/in_data      byte stream input; in_ready accepts it
//   out_write_*           one-cycle registered memory write port
//   out_core_run          high once loading finished (core reset inverse)
//   out_error             sticky protocol error
//   out_words_written     completed memory writes
// Frame: base address, word count N, N data words, and with
// LOADER_CHECKSUM_EN defined a trailing 32-bit sum of the data words.
//
// state   | meaning
// S_ADDR  | collecting base address
// S_COUNT | collecting word count
// S_DATA  | collecting data words, one write per word
// S_CSUM  | collecting checksum (LOADER_CHECKSUM_EN only)
// S_DONE  | image loaded, core released
// S_ERROR | protocol error, core held in reset
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS        = 65536,
  parameter bit          BASE_ALIGN_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_write_enable,
  output logic [31:0] out_write_address,
  output logic [31:0] out_write_data,
  output logic        out_core_run,
  output logic        out_error,
  output logic [31:0] out_words_written
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] words_q, words_d;
  logic        run_q, run_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        xfer;
  logic        word_done;
  logic [31:0] word;

  assign in_ready = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer     = in_valid && in_ready;

  byte_packer u_packer (
    .CLK          (CLK),
    .RESET        (RESET),
    .byte_valid_i (xfer),
    .byte_i       (in_data),
    .word_done_o  (word_done),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    // Released the cycle after S_DONE is entered, so the last write
    // strobe always precedes the core leaving reset.
    run_d   = run_q || (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_ADDR: if (word_done) begin
        if (BASE_ALIGN_CHECK && (word[1:0] != 2'b00)) begin
          state_d = S_ERROR;
        end else begin
          base_d  = {word[31:2], 2'b00};
          state_d = S_COUNT;
        end
      end
      S_COUNT: if (word_done) begin
        if (word == 32'd0) begin
          state_d = S_AFTER_DATA;
        end else if (word > MAX_WORDS) begin
          state_d = S_ERROR;
        end else begin
          count_d = word;
          idx_d   = 32'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (word_done) begin
        we_d    = 1'b1;
        waddr_d = base_q + (idx_q << 2);
        wdata_d = word;
        idx_d   = idx_q + 32'd1;
        words_d = words_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q + word;
`endif
        if (idx_q + 32'd1 == count_q) state_d = S_AFTER_DATA;
      end
      S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (word_done) state_d = (word == csum_q) ? S_DONE : S_ERROR;
`else
        state_d = S_ERROR;
`endif
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_ADDR;
      base_q  <= 32'd0;
      count_q <= 32'd0;
      idx_q   <= 32'd0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      words_q <= 32'd0;
      run_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      run_q   <= run_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign out_write_enable  = we_q;
  assign out_write_address = waddr_q;
  assign out_write_data    = wdata_q;
  assign out_words_written = words_q;
  assign out_core_run      = run_q;
  assign out_error         = (state_q == S_ERROR);

endmodule
